hamming_dec_engine: RTL and testbench

Hardware SECDED decode engine for the 16-bit Hamming(16,11) codewords used in program 2. On a `start` pulse it walks `NUM_WORDS` codewords stored as byte pairs in data memory and decodes each one. It writes a flagged 16-bit result back as byte pairs, then raises `done`. It sits beside the core on the data-memory port and replaces the software decode loop.

---
 rtl/hamming_pkg.sv | 28 ++
 rtl/secded_dec16.sv | 49 ++++
 rtl/hamming_dec_engine.sv | 124 ++++++++++++
 tb/tb_hamming_dec_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared flags, FSM states and codeword bit positions for the Hamming(16,11) decoder
package hamming_pkg;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_SGL  = 2'b01;
  localparam logic [1:0] FLAG_DBL  = 2'b10;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  function automatic logic is_parity_pos(input int k);
    return (k == P0_POS) || (k == P1_POS) || (k == P2_POS) ||
           (k == P4_POS) || (k == P8_POS);
  endfunction

endpackage

// File: rtl/secded_dec16.sv
// rtl/secded_dec16.sv - combinational SECDED decode of one 16-bit codeword into a flagged result
module secded_dec16
  import hamming_pkg::*;
(
  input  logic [15:0] cw,
  output logic [15:0] result,
  output logic        is_sgl,
  output logic        is_dbl
);

  logic [3:0]  syn;
  logic        q;
  logic [10:0] data;
  logic [1:0]  flag;
  int          n;

  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
  end

  assign q = ^cw;

  // A syndrome of 0 with odd parity points at p0, which never reaches the data field.
  always_comb begin
    data = '0;
    n    = 0;
    for (int k = 0; k < 16; k++) begin
      if (!is_parity_pos(k)) begin
        data[n[3:0]] = cw[k] ^ (q && (syn == 4'(k)));
        n = n + 1;
      end
    end
  end

  assign is_sgl = q;
  assign is_dbl = ~q & (syn != 4'd0);

  always_comb begin
    flag = FLAG_NONE;
    if (is_sgl)      flag = FLAG_SGL;
    else if (is_dbl) flag = FLAG_DBL;
  end

  assign result = {flag, 3'b000, data};

endmodule

// File: rtl/hamming_dec_engine.sv
// rtl/hamming_dec_engine.sv - memory-walking SECDED decode engine; HAMDEC_STATS_EN enables error counters
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done,
  output logic [3:0]    sgl_cnt,
  output logic [3:0]    dbl_cnt
);

  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [7:0]    lo_byte;
  logic [15:0]   result;
  logic [15:0]   dec_result;
  logic          is_sgl, is_dbl;
  logic          start_ok;
  logic [AW-1:0] off2;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign off2     = AW'({idx, 1'b0});

  secded_dec16 u_dec (
    .cw     ({mem_rdata, lo_byte}),
    .result (dec_result),
    .is_sgl (is_sgl),
    .is_dbl (is_dbl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      lo_byte <= '0;
      result  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok)            idx     <= '0;
      else if (state == WR_HI) idx     <= idx + 1'b1;
      if (state == RD_LO)      lo_byte <= mem_rdata;
      if (state == RD_HI)      result  <= dec_result;
    end
  end

  // Memory strobes decode straight from state so a reset kills mem_we without waiting for a clock.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = RD_LO;
      end
      RD_LO: begin
        mem_addr  = SRC_A + off2;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_addr  = SRC_A + off2 + AW'(1);
        state_nxt = WR_LO;
      end
      WR_LO: begin
        mem_addr  = DST_A + off2;
        mem_we    = 1'b1;
        mem_wdata = result[7:0];
        state_nxt = WR_HI;
      end
      WR_HI: begin
        mem_addr  = DST_A + off2 + AW'(1);
        mem_we    = 1'b1;
        mem_wdata = result[15:8];
        state_nxt = (idx < LAST_IDX) ? RD_LO : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

`ifdef HAMDEC_STATS_EN
  logic [3:0] sgl_q, dbl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgl_q <= '0;
      dbl_q <= '0;
    end else if (start_ok) begin
      sgl_q <= '0;
      dbl_q <= '0;
    end else if (state == RD_HI) begin
      if (is_sgl && (sgl_q != 4'hF)) sgl_q <= sgl_q + 4'd1;
      if (is_dbl && (dbl_q != 4'hF)) dbl_q <= dbl_q + 4'd1;
    end
  end

  assign sgl_cnt = sgl_q;
  assign dbl_cnt = dbl_q;
`else
  logic stats_unused;
  assign stats_unused = is_sgl | is_dbl;
  assign sgl_cnt      = '0;
  assign dbl_cnt      = '0;
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// tb/tb_hamming_dec_engine.sv - randomized scoreboard bench for hamming_dec_engine
module tb_hamming_dec_engine;

  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int NW  = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       busy, done;
  logic [3:0] sgl_cnt, dbl_cnt;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] mem [0:255];
  logic [7:0] exp_mem [0:2*NW-1];
  logic [7:0] sentinel [0:2*NW-1];
  wr_t        exp_q[$];
  int         exp_sgl, exp_dbl;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  hamming_dec_engine #(
    .SRC_BASE (SRC),
    .DST_BASE (DST),
    .NUM_WORDS(NW),
    .AW       (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .sgl_cnt  (sgl_cnt),
    .dbl_cnt  (dbl_cnt)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference code: data fills every non-power-of-two position, parity k covers indices with bit k set.
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] w;
    int          n;
    w = '0;
    n = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[n];
        n++;
      end
    end
    for (int k = 1; k < 16; k = k * 2) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p < 16; p++) if ((p & k) != 0 && p != k) par ^= w[p];
      w[k] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d;
    int          n;
    d = '0;
    n = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[n] = w[p];
        n++;
      end
    end
    return d;
  endfunction

  // Nearest-codeword search: distance 0 clean, distance 1 single, otherwise double.
  function automatic logic [15:0] ref_dec(input logic [15:0] cw, output int kind);
    logic [15:0] x;
    if (enc(extract(cw)) == cw) begin
      kind = 0;
      return {5'b00000, extract(cw)};
    end
    for (int b = 0; b < 16; b++) begin
      x = cw ^ (16'd1 << b);
      if (enc(extract(x)) == x) begin
        kind = 1;
        return {5'b01000, extract(x)};
      end
    end
    kind = 2;
    return {5'b10000, extract(cw)};
  endfunction

  function automatic int stat_exp(input int n);
`ifdef HAMDEC_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic prepare(input int mode);
    logic [15:0] cw, res;
    logic [15:0] directed [0:3];
    int          kind;
    directed[0] = 16'hFFFF;
    directed[1] = 16'h0020;
    directed[2] = 16'hFFFE;
    directed[3] = 16'h0028;
    exp_sgl = 0;
    exp_dbl = 0;
    for (int k = 0; k < NW; k++) begin
      case (mode)
        0:       cw = (k < 4) ? directed[k] : 16'($urandom);
        1:       cw = enc(11'($urandom)) ^ (16'd1 << $urandom_range(15, 0));
        default: cw = 16'($urandom);
      endcase
      mem[SRC + 2*k]     = cw[7:0];
      mem[SRC + 2*k + 1] = cw[15:8];
      res = ref_dec(cw, kind);
      if (kind == 1) exp_sgl++;
      if (kind == 2) exp_dbl++;
      exp_mem[2*k]     = res[7:0];
      exp_mem[2*k + 1] = res[15:8];
      sentinel[2*k]     = 8'($urandom);
      sentinel[2*k + 1] = 8'($urandom);
      mem[DST + 2*k]     = sentinel[2*k];
      mem[DST + 2*k + 1] = sentinel[2*k + 1];
    end
    if (exp_sgl > 15) exp_sgl = 15;
    if (exp_dbl > 15) exp_dbl = 15;
  endtask

  task automatic push_writes(input int n);
    wr_t e;
    for (int j = 0; j < n; j++) begin
      e.addr = 8'(DST + j);
      e.data = exp_mem[j];
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
      end
    end
  end

  task automatic do_run(input bit pulse_mid);
    int cycles;
    push_writes(2*NW);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cycles = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cycles == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_low_after_start", 32'(done), 32'd0);
      end
      if (done) break;
      start = pulse_mid && (cycles == 10 || cycles == 30);
      @(posedge clk);
      cycles++;
    end
    start = 1'b0;
    check("done_cycles", 32'(cycles), 32'd61);
    check("busy_in_done", 32'(busy), 32'd0);
    check("sgl_cnt", 32'(sgl_cnt), 32'(stat_exp(exp_sgl)));
    check("dbl_cnt", 32'(dbl_cnt), 32'(stat_exp(exp_dbl)));
    check("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int j = 0; j < 2*NW; j++) check("mem_result", {24'd0, mem[DST + j]}, {24'd0, exp_mem[j]});
  endtask

  task automatic reset_midrun();
    bit hit;
    hit = 1'b0;
    prepare(2);
    push_writes(11);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_we && mem_addr == 8'(DST + 10)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_word5", 32'(hit), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_sgl", 32'(sgl_cnt), 32'd0);
    check("rst_dbl", 32'(dbl_cnt), 32'd0);
    for (int j = 0; j < 2*NW; j++) begin
      if (j < 10) check("kept_partial", {24'd0, mem[DST + j]}, {24'd0, exp_mem[j]});
      else        check("untouched", {24'd0, mem[DST + j]}, {24'd0, sentinel[j]});
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("reset_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_we", 32'(mem_we), 32'd0);
    check("reset_wdata", {24'd0, mem_wdata}, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sgl", 32'(sgl_cnt), 32'd0);
    check("reset_dbl", 32'(dbl_cnt), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    prepare(0);
    do_run(1'b0);
    prepare(1);
    do_run(1'b0);
    prepare(2);
    do_run(1'b1);
    reset_midrun();
    prepare(2);
    do_run(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
